kmcmem_mux: RTL and testbench

Parametrised memory/address-register block for the KMC11 microprocessor datapath and its successors. It provides a width-configurable data RAM with NMAR independently addressable memory address registers (MARs) and a sticky per-MAR wrap flag. It also has a second, host-side four-phase request/acknowledge port so the Unibus/console side can read and write the RAM while the microengine is idle. It sits between the KMC ALU/CRAM decode and the Unibus register interface.

---
 rtl/kmcmem_mux.sv | 127 ++++++++++++
 tb/tb_kmcmem_mux.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kmcmem_mux.sv
// KMC11 memory/address-register block: data RAM addressed through NMAR MARs,
// with a host-side four-phase port that borrows the RAM while the CPU is idle.

module kmcmem_mux_mar #(
   parameter int AW = 10,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          init,
   input  logic          hit,
   input  logic [1:0]    op,
   input  logic [DW-1:0] wdata,
   output logic [AW-1:0] value,
   output logic          ovf
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value <= '0;
         ovf   <= 1'b0;
      end else if (init) begin
         value <= '0;
         ovf   <= 1'b0;
      end else if (hit) begin
         case (op)
            2'b01: value[DW-1:0] <= wdata;
            2'b10: begin
               value[AW-1:DW] <= wdata[AW-DW-1:0];
               ovf            <= 1'b0;
            end
            2'b11: begin
               value <= value + AW'(1);
               // wrap flag is sticky until load high or init
               if (&value) ovf <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

module kmcmem_mux #(
   parameter int AW   = 10,
   parameter int DW   = 8,
   parameter int NMAR = 2,
   parameter int SW   = (NMAR > 1) ? $clog2(NMAR) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            init,
   input  logic            cpu_en,
   input  logic [SW-1:0]   mar_sel,
   input  logic [1:0]      mar_op,
   input  logic            mem_wr,
   input  logic [DW-1:0]   wdata,
   output logic [AW-1:0]   mar,
   output logic [NMAR-1:0] mar_ovf,
   output logic [DW-1:0]   rdata,
   input  logic            host_req,
   input  logic            host_wr,
   input  logic [AW-1:0]   host_addr,
   input  logic [DW-1:0]   host_wdata,
   output logic            host_ack,
   output logic [DW-1:0]   host_rdata
);

   localparam int DEPTH = 1 << AW;
   localparam logic [SW:0] NMAR_W = (SW+1)'(NMAR);

   typedef enum logic [1:0] {IDLE, ACK, RELEASE} hstate_t;

   hstate_t                   state;
   logic [NMAR-1:0][AW-1:0]   mar_q;
   logic [DW-1:0]             ram [0:DEPTH-1];
   logic                      sel_ok;
   logic                      host_acc;

   assign sel_ok   = {1'b0, mar_sel} < NMAR_W;
   assign mar      = sel_ok ? mar_q[mar_sel] : '0;
   // CPU owns the RAM whenever cpu_en=1, so a host access never meets a CPU write
   assign host_acc = (state == IDLE) && host_req && !cpu_en;

   for (genvar g = 0; g < NMAR; g++) begin : g_mar
      kmcmem_mux_mar #(.AW(AW), .DW(DW)) u_mar (
         .clk   (clk),
         .rst   (rst),
         .init  (init),
         .hit   (cpu_en && sel_ok && (mar_sel == SW'(g))),
         .op    (mar_op),
         .wdata (wdata),
         .value (mar_q[g]),
         .ovf   (mar_ovf[g])
      );
   end

   always_ff @(posedge clk) begin
      if (host_acc && host_wr)
         ram[host_addr] <= host_wdata;
      else if (cpu_en && mem_wr && sel_ok)
         ram[mar] <= wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         host_ack   <= 1'b0;
         host_rdata <= '0;
         rdata      <= '0;
      end else begin
         host_ack <= 1'b0;
         if (!host_acc) rdata <= ram[mar];
         case (state)
            IDLE: if (host_acc) begin
               state    <= ACK;
               host_ack <= 1'b1;
               if (!host_wr) host_rdata <= ram[host_addr];
            end
            ACK:     state <= RELEASE;
            RELEASE: if (!host_req) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_kmcmem_mux.sv
// Bench for kmcmem_mux: directed scenarios plus a randomized run, all checked
// against a behavioural model of MARs, RAM and host handshake.

module tb_kmcmem_mux;

   localparam int AW    = 10;
   localparam int DW    = 8;
   localparam int NMAR  = 2;
   localparam int SW    = 1;
   localparam int DEPTH = 1 << AW;
   localparam int LO    = 1 << DW;
   localparam int HI    = 1 << (AW - DW);

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            init = 1'b0;
   logic            cpu_en = 1'b0;
   logic [SW-1:0]   mar_sel = '0;
   logic [1:0]      mar_op = 2'b00;
   logic            mem_wr = 1'b0;
   logic [DW-1:0]   wdata = '0;
   logic [AW-1:0]   mar;
   logic [NMAR-1:0] mar_ovf;
   logic [DW-1:0]   rdata;
   logic            host_req = 1'b0;
   logic            host_wr = 1'b0;
   logic [AW-1:0]   host_addr = '0;
   logic [DW-1:0]   host_wdata = '0;
   logic            host_ack;
   logic [DW-1:0]   host_rdata;

   int checks = 0;
   int errors = 0;

   // behavioural model
   int            mar_m [NMAR];
   bit            ovf_m [NMAR];
   logic [DW-1:0] ram_m [DEPTH];
   logic [DW-1:0] rd_m;
   logic [DW-1:0] hrd_m;
   bit            ack_m;
   int            hphase;   // 0 idle, 1 acknowledging, 2 waiting for req to drop

   kmcmem_mux #(.AW(AW), .DW(DW), .NMAR(NMAR), .SW(SW)) dut (
      .clk(clk), .rst(rst), .init(init), .cpu_en(cpu_en), .mar_sel(mar_sel),
      .mar_op(mar_op), .mem_wr(mem_wr), .wdata(wdata), .mar(mar), .mar_ovf(mar_ovf),
      .rdata(rdata), .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < NMAR; i++) begin
         mar_m[i] = 0;
         ovf_m[i] = 1'b0;
      end
      rd_m = '0; hrd_m = '0; ack_m = 1'b0; hphase = 0;
   endtask

   task automatic model_step();
      bit acc, ok;
      int cur, s;
      s   = int'(mar_sel);
      ok  = s < NMAR;
      cur = ok ? mar_m[s] : 0;
      acc = (hphase == 0) && host_req && !cpu_en;
      ack_m = acc;
      if (!acc) rd_m = ram_m[cur];
      else if (!host_wr) hrd_m = ram_m[int'(host_addr)];
      case (hphase)
         0: if (acc) hphase = 1;
         1: hphase = 2;
         default: if (!host_req) hphase = 0;
      endcase
      if (cpu_en && mem_wr && ok) ram_m[cur] = wdata;
      if (acc && host_wr) ram_m[int'(host_addr)] = host_wdata;
      if (init) begin
         for (int i = 0; i < NMAR; i++) begin
            mar_m[i] = 0;
            ovf_m[i] = 1'b0;
         end
      end else if (cpu_en && ok) begin
         case (mar_op)
            2'b01: mar_m[s] = (mar_m[s] / LO) * LO + int'(wdata);
            2'b10: begin
               mar_m[s] = (int'(wdata) % HI) * LO + mar_m[s] % LO;
               ovf_m[s] = 1'b0;
            end
            2'b11: begin
               if (mar_m[s] == DEPTH - 1) begin
                  mar_m[s] = 0;
                  ovf_m[s] = 1'b1;
               end else mar_m[s] = mar_m[s] + 1;
            end
            default: ;
         endcase
      end
   endtask

   // advance one clock; model follows the inputs present at the edge
   task automatic tick();
      if (!rst) model_reset();
      else model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu(input bit en, input int sel, input int op, input bit wr, input int wd);
      cpu_en  = en;
      mar_sel = SW'(sel);
      mar_op  = 2'(op);
      mem_wr  = wr;
      wdata   = DW'(wd);
   endtask

   function automatic logic [NMAR-1:0] ovf_exp();
      logic [NMAR-1:0] v;
      for (int i = 0; i < NMAR; i++) v[i] = ovf_m[i];
      return v;
   endfunction

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      checks++;
      if (mar !== '0 || mar_ovf !== '0 || rdata !== '0 || host_ack !== 1'b0 || host_rdata !== '0) begin
         errors++;
         $display("FAIL reset: mar=%0h ovf=%0b rdata=%0h ack=%0b hrd=%0h required all zero",
                  mar, mar_ovf, rdata, host_ack, host_rdata);
      end
      rst = 1'b1;
   endtask

   // walk MAR0 through every address writing random data; ends with a wrap
   task automatic test_fill();
      cpu(1, 0, 1, 0, 0); tick();
      cpu(1, 0, 2, 0, 0); tick();
      for (int i = 0; i < DEPTH; i++) begin
         cpu(1, 0, 3, 1, int'($urandom_range(0, LO - 1)));
         tick();
         checks++;
         if (mar !== AW'(mar_m[0])) begin
            errors++;
            $display("FAIL fill_mar: got %0h required %0h", mar, mar_m[0]);
         end
      end
      cpu(0, 0, 0, 0, 0); tick();
      checks++;
      if (mar !== '0 || mar_ovf !== 2'b01) begin
         errors++;
         $display("FAIL fill_wrap: mar=%0h ovf=%0b required 0 / 01", mar, mar_ovf);
      end
   endtask

   task automatic test_init();
      cpu(1, 1, 1, 0, 'h55); tick();
      init = 1'b1;
      cpu(1, 1, 3, 0, 0); tick();
      init = 1'b0;
      checks++;
      if (mar !== '0 || mar_ovf !== '0) begin
         errors++;
         $display("FAIL init_clear: mar1=%0h ovf=%0b required 0 / 00", mar, mar_ovf);
      end
      cpu(0, 0, 0, 0, 0); tick(); tick();
      checks++;
      if (mar !== '0 || rdata !== rd_m) begin
         errors++;
         $display("FAIL init_ram_kept: mar0=%0h rdata=%0h required 0 / %0h", mar, rdata, rd_m);
      end
   endtask

   task automatic test_load_write();
      cpu(1, 0, 1, 0, 'h34); tick();
      cpu(1, 0, 2, 0, 'h03); tick();
      checks++;
      if (mar !== 10'h334) begin
         errors++;
         $display("FAIL load_mar: got %0h required 334", mar);
      end
      cpu(1, 0, 0, 1, 'hA5); tick();
      cpu(1, 0, 0, 0, 0); tick();
      checks++;
      if (rdata !== 8'hA5 || mar_ovf !== 2'b00) begin
         errors++;
         $display("FAIL load_write: rdata=%0h ovf=%0b required a5 / 00", rdata, mar_ovf);
      end
   endtask

   task automatic test_wrap();
      cpu(1, 1, 1, 0, 'hFF); tick();
      cpu(1, 1, 2, 0, 'h03); tick();
      checks++;
      if (mar !== 10'h3FF) begin
         errors++;
         $display("FAIL wrap_load: got %0h required 3ff", mar);
      end
      cpu(1, 1, 3, 0, 0); tick();
      checks++;
      if (mar !== 10'h000 || mar_ovf !== 2'b10) begin
         errors++;
         $display("FAIL wrap_inc: mar=%0h ovf=%0b required 0 / 10", mar, mar_ovf);
      end
      cpu(1, 1, 2, 0, 0); tick();
      checks++;
      if (mar_ovf !== 2'b00) begin
         errors++;
         $display("FAIL wrap_clear: ovf=%0b required 00", mar_ovf);
      end
      cpu(1, 0, 0, 0, 0); tick();
      checks++;
      if (mar !== 10'h334) begin
         errors++;
         $display("FAIL wrap_mar0_kept: got %0h required 334", mar);
      end
   endtask

   task automatic test_read_first();
      cpu(1, 0, 0, 1, 'h11); tick();
      cpu(1, 0, 0, 1, 'h22); tick();
      checks++;
      if (rdata !== 8'h11) begin
         errors++;
         $display("FAIL read_first_old: got %0h required 11", rdata);
      end
      cpu(1, 0, 0, 1, 'hA5); tick();
      checks++;
      if (rdata !== 8'h22) begin
         errors++;
         $display("FAIL read_first_new: got %0h required 22", rdata);
      end
      cpu(1, 0, 0, 0, 0); tick();
   endtask

   task automatic test_host_wait();
      logic [DW-1:0] rd_hold;
      host_req = 1'b1; host_wr = 1'b0; host_addr = 10'h334;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (host_ack !== 1'b0) begin
            errors++;
            $display("FAIL host_blocked: ack=%0b required 0 at cycle %0d", host_ack, i);
         end
      end
      rd_hold = rdata;
      cpu(0, 0, 0, 0, 0); tick();
      checks++;
      if (host_ack !== 1'b1 || host_rdata !== 8'hA5 || rdata !== rd_hold) begin
         errors++;
         $display("FAIL host_read: ack=%0b hrd=%0h rdata=%0h required 1 / a5 / %0h",
                  host_ack, host_rdata, rdata, rd_hold);
      end
      tick(); tick();
      checks++;
      if (host_ack !== 1'b0 || host_rdata !== 8'hA5) begin
         errors++;
         $display("FAIL host_pulse: ack=%0b hrd=%0h required 0 / a5", host_ack, host_rdata);
      end
      host_req = 1'b0; tick();
   endtask

   task automatic test_host_write();
      bit seen = 1'b0;
      host_req = 1'b1; host_wr = 1'b1; host_addr = 10'h010; host_wdata = 8'h5A;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         seen = host_ack;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL host_write_ack: ack=0 required 1 within 10 cycles");
      end
      host_req = 1'b0; host_wr = 1'b0; tick();
      cpu(1, 0, 1, 0, 'h10); tick();
      cpu(1, 0, 2, 0, 'h00); tick();
      cpu(1, 0, 0, 0, 0); tick();
      checks++;
      if (mar !== 10'h010 || rdata !== 8'h5A) begin
         errors++;
         $display("FAIL host_write_data: mar=%0h rdata=%0h required 010 / 5a", mar, rdata);
      end
   endtask

   task automatic test_rst_host();
      host_req = 1'b1; host_wr = 1'b0; host_addr = 10'h334;
      cpu(1, 0, 0, 0, 0); tick(); tick();
      rst = 1'b0;
      cpu(0, 0, 0, 0, 0);
      tick(); tick();
      checks++;
      if (host_ack !== 1'b0 || mar !== '0) begin
         errors++;
         $display("FAIL rst_host: ack=%0b mar=%0h required 0 / 0", host_ack, mar);
      end
      host_req = 1'b0;
      rst = 1'b1;
      tick();
      host_req = 1'b1; tick();
      checks++;
      if (host_ack !== 1'b1 || host_rdata !== 8'hA5) begin
         errors++;
         $display("FAIL rst_host_retry: ack=%0b hrd=%0h required 1 / a5", host_ack, host_rdata);
      end
      host_req = 1'b0; tick();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         cpu(($urandom_range(0, 3) != 0), int'($urandom_range(0, NMAR - 1)),
             int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
             int'($urandom_range(0, LO - 1)));
         init = ($urandom_range(0, 19) == 0);
         if (!host_req && $urandom_range(0, 3) == 0) begin
            host_req   = 1'b1;
            host_wr    = $urandom_range(0, 1) == 1;
            host_addr  = AW'($urandom_range(0, DEPTH - 1));
            host_wdata = DW'($urandom_range(0, LO - 1));
         end
         tick();
         checks++;
         if (mar !== AW'(mar_m[int'(mar_sel)]) || mar_ovf !== ovf_exp() || rdata !== rd_m ||
             host_ack !== ack_m || host_rdata !== hrd_m) begin
            errors++;
            $display("FAIL random[%0d]: mar=%0h/%0h ovf=%0b/%0b rd=%0h/%0h ack=%0b/%0b hrd=%0h/%0h",
                     n, mar, mar_m[int'(mar_sel)], mar_ovf, ovf_exp(), rdata, rd_m,
                     host_ack, ack_m, host_rdata, hrd_m);
         end
         if (ack_m) host_req = 1'b0;
      end
      init = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) ram_m[i] = '0;
      model_reset();
      test_reset();
      test_fill();
      test_init();
      test_load_write();
      test_wrap();
      test_read_first();
      test_host_wait();
      test_host_write();
      test_rst_host();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
